// File: rtl/lector_contadores.sv
// lector_contadores
// Bus master for the transition-counter memory. On start it walks every
// counter address, reads the 32-bit count, streams {address, count} out over
// a valid/ready handshake and accumulates a grand total. In read-and-clear
// mode each counter is written back to zero right after it has been read.
//
// Ports:
//   clk, reset_L           clock (rising edge), async active-low reset
//   start, clear_en        scan request and read-and-clear mode (sampled in IDLE)
//   dir, LE, dato          memory address, control (1 = read, 0 = write), data bus
//   out_valid, out_ready   sample handshake
//   out_dir, out_data      sample address and count
//   total, total_valid     sum of counts from the last completed scan
//   busy, done             scan in progress / one-cycle completion pulse
module lector_contadores #(
  parameter int unsigned NUM_CNTR = 12,
  parameter int unsigned DIR_W    = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SUM_W    = 36
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              start,
  input  logic              clear_en,
  output logic [DIR_W-1:0]  dir,
  output logic              LE,
  inout  wire  [DATA_W-1:0] dato,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DIR_W-1:0]  out_dir,
  output logic [DATA_W-1:0] out_data,
  output logic [SUM_W-1:0]  total,
  output logic              total_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CAP,
    SEND,
    WR,
    WREC,
    NEXT,
    DONE
  } state_t;

  localparam logic [DIR_W-1:0] LAST_IDX = DIR_W'(NUM_CNTR - 1);

  state_t             state;
  logic [DIR_W-1:0]   idx;
  logic [SUM_W-1:0]   acc;
  logic               clr_q;

  // The bus is driven (with zeros) only while LE is low, i.e. only in WR.
  // LE is a register with an async set, so reset releases the bus at once.
  assign dato = LE ? {DATA_W{1'bz}} : '0;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state       <= IDLE;
      idx         <= '0;
      acc         <= '0;
      clr_q       <= 1'b0;
      dir         <= '0;
      LE          <= 1'b1;
      out_valid   <= 1'b0;
      out_dir     <= '0;
      out_data    <= '0;
      total       <= '0;
      total_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            clr_q       <= clear_en;
            idx         <= '0;
            acc         <= '0;
            total_valid <= 1'b0;
            dir         <= '0;
            busy        <= 1'b1;
            state       <= ADDR;
          end
        end

        // Address settle cycle; dir was loaded on the edge entering ADDR.
        ADDR: state <= CAP;

        CAP: begin
          out_data  <= dato;
          out_dir   <= idx;
          acc       <= acc + {{(SUM_W-DATA_W){1'b0}}, dato};
          out_valid <= 1'b1;
          state     <= SEND;
        end

        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (clr_q) begin
              LE    <= 1'b0;
              state <= WR;
            end else begin
              state <= NEXT;
            end
          end
        end

        WR: begin
          LE    <= 1'b1;
          state <= WREC;
        end

        // Recovery cycle keeps dir stable until the write has completed.
        WREC: state <= NEXT;

        // total/total_valid/done are loaded on entry to DONE so that they
        // become visible in the same cycle as the done pulse.
        NEXT: begin
          if (idx == LAST_IDX) begin
            total       <= acc;
            total_valid <= 1'b1;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            dir   <= idx + 1'b1;
            state <= ADDR;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lector_contadores.sv
// Testbench for lector_contadores: behavioural counter memory, expected
// sample queue and total computed from the preloaded values.
module tb_lector_contadores;

  localparam int unsigned N    = 12;
  localparam int unsigned DW   = 4;
  localparam int unsigned DATW = 32;
  localparam int unsigned SW   = 36;

  logic            clk = 1'b0;
  logic            reset_L = 1'b0;
  logic            start = 1'b0;
  logic            clear_en = 1'b0;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   dir;
  logic            LE;
  wire  [DATW-1:0] dato;
  logic            out_valid;
  logic [DW-1:0]   out_dir;
  logic [DATW-1:0] out_data;
  logic [SW-1:0]   total;
  logic            total_valid;
  logic            busy;
  logic            done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATW-1:0] mem [16];
  logic [DATW-1:0] pre [16];
  logic            load_req = 1'b0;

  lector_contadores #(
    .NUM_CNTR(N),
    .DIR_W   (DW),
    .DATA_W  (DATW),
    .SUM_W   (SW)
  ) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .start      (start),
    .clear_en   (clear_en),
    .dir        (dir),
    .LE         (LE),
    .dato       (dato),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_dir    (out_dir),
    .out_data   (out_data),
    .total      (total),
    .total_valid(total_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Counter memory: drives the bus while LE=1, writes the bus while LE=0.
  assign dato = LE ? mem[dir] : {DATW{1'bz}};

  always @(posedge clk) begin
    if (load_req) mem <= pre;
    else if (!LE) mem[dir] <= dato;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_dir",         64'(dir),         64'(0));
    check("rst_LE",          64'(LE),          64'(1));
    check("rst_out_valid",   64'(out_valid),   64'(0));
    check("rst_out_dir",     64'(out_dir),     64'(0));
    check("rst_out_data",    64'(out_data),    64'(0));
    check("rst_total",       64'(total),       64'(0));
    check("rst_total_valid", 64'(total_valid), 64'(0));
    check("rst_busy",        64'(busy),        64'(0));
    check("rst_done",        64'(done),        64'(0));
  endtask

  task automatic do_load();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // One full scan. stall_addr/rst_addr/pulse_cyc < 0 disable that feature;
  // exp_cyc = 0 skips the latency check.
  task automatic run_scan(input bit clr, input bit rnd_ready, input int stall_addr,
                          input int stall_len, input int rst_addr, input int pulse_cyc,
                          input int exp_cyc);
    logic [DW+DATW-1:0] exp_q [$];
    logic [DW+DATW-1:0] e;
    logic [SW-1:0]      exp_total;
    logic [DW-1:0]      hold_dir;
    logic [DATW-1:0]    hold_data;
    int cyc, le_low, stall_left, nsamp;
    bit got_done, was_reset, prev_le, prev_hold;

    exp_total = '0;
    cyc = 0; le_low = 0; stall_left = stall_len; nsamp = 0;
    got_done = 0; was_reset = 0; prev_le = 1; prev_hold = 0;
    hold_dir = '0; hold_data = '0;
    for (int i = 0; i < N; i++) begin
      exp_q.push_back({DW'(i), pre[i]});
      exp_total += SW'(pre[i]);
    end
    do_load();

    start = 1'b1;
    clear_en = clr;
    out_ready = 1'b1;
    while (!got_done && !was_reset && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = (cyc == pulse_cyc);
      if (cyc == 1) begin
        check("busy_at_start", 64'(busy), 64'(1));
        check("tv_cleared", 64'(total_valid), 64'(0));
      end
      check("dir_range", 64'(int'(dir) < N), 64'(1));
      if (prev_hold) begin
        check("hold_valid", 64'(out_valid), 64'(1));
        check("hold_out_dir", 64'(out_dir), 64'(hold_dir));
        check("hold_out_data", 64'(out_data), 64'(hold_data));
        check("hold_dir", 64'(dir), 64'(hold_dir));
        check("hold_LE", 64'(LE), 64'(1));
      end
      if (!LE) begin
        le_low++;
        check("wr_dato", 64'(dato), 64'(0));
        check("le_single", 64'(prev_le), 64'(1));
        check("wr_dir", 64'(dir), 64'(out_dir));
      end
      prev_le = LE;

      if (rst_addr >= 0 && out_valid && int'(out_dir) == rst_addr) begin
        reset_L = 1'b0;
        #1;
        check_reset_outputs();
        was_reset = 1;
      end else begin
        if (out_valid) check("send_dir", 64'(dir), 64'(out_dir));
        out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (out_valid && stall_left > 0 && int'(out_dir) == stall_addr) begin
          out_ready = 1'b0;
          stall_left--;
        end
        prev_hold = out_valid && !out_ready;
        hold_dir  = out_dir;
        hold_data = out_data;
        if (out_valid && out_ready) begin
          nsamp++;
          if (exp_q.size() == 0) begin
            check("extra_sample", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check("sample_dir", 64'(out_dir), 64'(e[DW+DATW-1:DATW]));
            check("sample_data", 64'(out_data), 64'(e[DATW-1:0]));
          end
        end
        if (done) got_done = 1;
      end
    end

    if (was_reset) begin
      @(negedge clk);
      check_reset_outputs();
      reset_L = 1'b1;
      for (int i = 0; i < N; i++)
        check("mem_after_reset", 64'(mem[i]), 64'((i < rst_addr) ? 0 : pre[i]));
    end else begin
      check("scan_timeout", 64'(got_done), 64'(1));
      if (exp_cyc > 0) check("done_latency", 64'(cyc), 64'(exp_cyc));
      check("total", 64'(total), 64'(exp_total));
      check("total_valid", 64'(total_valid), 64'(1));
      check("sample_count", 64'(nsamp), 64'(N));
      check("missing_samples", 64'(exp_q.size()), 64'(0));
      check("le_low_cycles", 64'(le_low), 64'(clr ? N : 0));
      @(negedge clk);
      check("done_pulse", 64'(done), 64'(0));
      check("idle_busy", 64'(busy), 64'(0));
      check("tv_hold", 64'(total_valid), 64'(1));
      for (int i = 0; i < N; i++)
        check("mem_after_scan", 64'(mem[i]), 64'(clr ? 0 : pre[i]));
    end
    out_ready = 1'b0;
    clear_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) pre[i] = '0;
    reset_L = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    reset_L = 1'b1;
    @(negedge clk);

    // Ascending pattern, no clear.
    for (int i = 0; i < N; i++) pre[i] = DATW'(100 * i + 1);
    run_scan(1'b0, 1'b0, -1, 0, -1, -1, 49);
    check("t1_total_const", 64'(total), 64'(6612));

    // All ones: total must not truncate.
    for (int i = 0; i < N; i++) pre[i] = 32'hFFFF_FFFF;
    run_scan(1'b0, 1'b0, -1, 0, -1, -1, 49);
    check("max_total_const", 64'(total), 64'(36'hBFFFFFFF4));

    // Read-and-clear.
    for (int i = 0; i < N; i++) pre[i] = DATW'(100 * i + 1);
    run_scan(1'b1, 1'b0, -1, 0, -1, -1, 73);
    check("clr_total_const", 64'(total), 64'(6612));

    // Back-pressure at address 5 for 10 cycles.
    for (int i = 0; i < N; i++) pre[i] = DATW'(100 * i + 1);
    run_scan(1'b0, 1'b0, 5, 10, -1, -1, 59);

    // Random data, random ready, random mode, spurious start mid-scan.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++) pre[i] = $urandom;
      run_scan(1'($urandom_range(0, 1)), 1'b1, -1, 0, -1, 20, 0);
    end

    // Reset while presenting address 7 in clear mode.
    for (int i = 0; i < N; i++) pre[i] = DATW'(100 * i + 1);
    run_scan(1'b1, 1'b0, -1, 0, 7, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lector_contadores.md
Name: lector_contadores

Overview:
- Bus master for the transition-counter memory: drives the memory-side `dir`, `LE` and `dato` lines.
- On `start` it scans every counter address, reads each 32-bit count and streams `{address, count}` out over a valid/ready handshake.
- Accumulates a grand total of all counts.
- Optionally zeroes each counter immediately after reading it (read-and-clear), so power-estimation windows can be sampled back to back.

Parameters:
- NUM_CNTR, 12, number of counters scanned (addresses 0..NUM_CNTR-1).
- DIR_W, 4, address width; 2^DIR_W >= NUM_CNTR.
- DATA_W, 32, counter width.
- SUM_W, 36, total accumulator width; must hold NUM_CNTR*(2^DATA_W-1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_L  input  1  asynchronous active-low reset.
- start  input  1  begin a scan; sampled only in IDLE.
- clear_en  input  1  read-and-clear mode; sampled with start and held for the whole scan.
- dir  output  DIR_W  counter address to memory.
- LE  output  1  memory control: 1 = memory drives `dato` (read), 0 = memory writes `dato`.
- dato  inout  DATA_W  memory data; block drives 0 only while LE=0, otherwise high-Z.
- out_valid  output  1  out_dir/out_data hold a valid sample.
- out_ready  input  1  consumer accepts the sample.
- out_dir  output  DIR_W  address of the sample.
- out_data  output  DATA_W  count read.
- total  output  SUM_W  sum of all counts from the last completed scan.
- total_valid  output  1  total is valid.
- busy  output  1  scan in progress (state != IDLE).
- done  output  1  one-cycle pulse at scan completion.

Behaviour:
- Reset (async, reset_L=0) forces:
  - state = IDLE, dir = 0, LE = 1, dato = Z, out_valid = 0, out_dir = 0, out_data = 0, total = 0, total_valid = 0, busy = 0, done = 0.
  - Index and accumulator are cleared.
- Reset asserted mid-scan: same values, immediately. Any counter cleared before the reset stays cleared. If reset arrives in WR, LE returns to 1 asynchronously.
- LE is 1 in every state except WR; LE=0 is never asserted for more than one cycle. dato is driven only in WR.
- States and transitions:
  - IDLE: if start=1, latch clear_en into clr_q, idx=0, acc=0, total_valid=0 -> ADDR. Otherwise stay.
  - ADDR: dir = idx, LE = 1 (settle cycle) -> CAP.
  - CAP: out_data <= dato, out_dir <= idx, acc <= acc + dato (zero-extended to SUM_W) -> SEND.
  - SEND: out_valid = 1; out_dir and out_data must stay stable until the transfer.
    - Transfer occurs on a cycle with out_valid & out_ready. out_valid drops on the next cycle.
    - After transfer: go to WR if clr_q=1, else to NEXT.
  - WR: dir = idx, LE = 0, dato = 0 -> WREC.
  - WREC: LE = 1, dato = Z; one recovery cycle so the write finishes before the address changes -> NEXT.
  - NEXT: if idx == NUM_CNTR-1 -> DONE, else idx <= idx+1 -> ADDR.
  - DONE: total <= acc, total_valid <= 1, done = 1 for this cycle only -> IDLE.
- dir changes only on the ADDR entry edge and holds through CAP, SEND, WR and WREC.
- start while busy is ignored. start in the same cycle DONE returns to IDLE is not seen; it must be presented in IDLE.
- total_valid stays 1 from DONE until the next accepted start.
- The accumulator never overflows within SUM_W for the default parameters; no saturation logic.
- Latency with out_ready held at 1:
  - Per counter: 4 cycles without clear (ADDR, CAP, SEND, NEXT); 6 cycles with clear.
  - Whole scan: start accepted -> done = 4*NUM_CNTR + 1 cycles (49 at defaults); 6*NUM_CNTR + 1 (73) with clear.
- Back-pressure: holding out_ready=0 stalls in SEND indefinitely. dir and LE=1 stay constant, so there is no memory side effect.
- Index wrap: idx never exceeds NUM_CNTR-1, so unused addresses (12..15 at defaults) are never accessed.

Test Plan:
- Preload counters i = 100*i+1; start, clear_en=0, out_ready=1 -> 12 transfers (0,1),(1,101)..(11,1101) in order, each addr once. Then done pulse after 49 cycles, total = 6612, total_valid=1, memory unchanged.
- Preload all counters 32'hFFFFFFFF, scan -> total = 36'hBFFFFFFF4 (12*(2^32-1)) with no truncation.
- clear_en=1, preload as in test 1 -> same 12 samples and total. Memory reads all zero afterwards. LE low for exactly 12 single cycles, dato = 0 in those cycles and Z otherwise.
- Hold out_ready=0 for 10 cycles at address 5 -> out_valid=1, out_data=501 and dir=5 stable, LE=1 throughout; no extra or duplicate sample after release.
- Pulse start mid-scan -> ignored, sample sequence unchanged. Assert reset_L=0 at address 7 in clear mode -> all outputs at reset values immediately, LE=1. Counters 0..6 read zero, counters 7..11 keep their preloaded values.
